// File: rtl/mp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mp_pkg
//  Description : Shared constants, FSM state type and sizing helpers for the
//                limb-serial multi-precision arithmetic blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package mp_pkg;

    // Default slice width processed per clock
    localparam int C_LIMB = 64;

    // Sequencer states, fixed 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mp_state_t;

    // Limbs needed so the extended operand always has headroom above bit WIDTH-1
    function automatic int nlimb(input int width, input int limb = C_LIMB);
        return width / limb + 1;
    endfunction

    // Limb counter width; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : mp_pkg
`default_nettype wire

// File: rtl/mp_limb_add.sv
`default_nettype none
// ============================================================================
//  Module      : mp_limb_add
//  Description : Combinational LIMB-bit adder with carry in and carry out.
//  Revision    : 1.0 - initial release
// ============================================================================
module mp_limb_add
    import mp_pkg::*;
#(
    parameter int LIMB = C_LIMB
) (
    input  logic [LIMB-1:0] a,
    input  logic [LIMB-1:0] b,
    input  logic            cin,
    output logic [LIMB-1:0] sum,
    output logic            cout
);

    // Widen by one bit so the carry out falls out of the addition directly
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{LIMB{1'b0}}, cin};

endmodule : mp_limb_add
`default_nettype wire

// File: rtl/mp_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mp_addsub_seq
//  Description : Limb-serial multi-precision adder/subtractor. Latches two
//                WIDTH-bit operands on start, adds one LIMB slice per cycle
//                and presents a (WIDTH+1)-bit two's-complement result with a
//                one-cycle done pulse.
//  Config      : MP_ADDSUB_BUSY_EN - adds a busy output (high while an
//                operation is in flight, RUN and DONE states).
//  Revision    : 1.0 - initial release
// ============================================================================
module mp_addsub_seq
    import mp_pkg::*;
#(
    parameter int WIDTH = 514,
    parameter int LIMB  = C_LIMB
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             done
`ifdef MP_ADDSUB_BUSY_EN
    ,
    output logic             busy
`endif
);

    localparam int NLIMB = nlimb(WIDTH, LIMB);
    localparam int EXT   = NLIMB * LIMB;
    localparam int CW    = cnt_width(NLIMB);

    localparam logic [CW-1:0] c_last_cnt = CW'(NLIMB - 1);

    mp_state_t          r_state;
    mp_state_t          w_state_nxt;
    logic [EXT-1:0]     r_a;
    logic [EXT-1:0]     r_b;
    logic [EXT-1:0]     r_acc;
    logic               r_carry;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     r_result;
    logic               r_done;
    logic [LIMB-1:0]    w_sum;
    logic               w_cout;

    // Low limbs of the shifting operands feed the single slice adder
    mp_limb_add #(
        .LIMB (LIMB)
    ) u_limb_add (
        .a    (r_a[LIMB-1:0]),
        .b    (r_b[LIMB-1:0]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: DONE always returns to IDLE so no start is queued
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (r_cnt == c_last_cnt) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: operand load, per-limb add/shift, result capture and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1; the +1 rides in on the carry
                        r_a     <= {{(EXT-WIDTH){1'b0}}, in_a};
                        r_b     <= subtract ? ~{{(EXT-WIDTH){1'b0}}, in_b}
                                            :  {{(EXT-WIDTH){1'b0}}, in_b};
                        r_carry <= subtract;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> LIMB;
                    r_b     <= r_b >> LIMB;
                    r_acc   <= {w_sum, r_acc[EXT-1:LIMB]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                end
                DONE: begin
                    // Bits above WIDTH and the final carry are discarded
                    r_result <= r_acc[WIDTH:0];
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;

`ifdef MP_ADDSUB_BUSY_EN
    assign busy = (r_state != IDLE);
`endif

endmodule : mp_addsub_seq
`default_nettype wire
